scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 110 +++++++++++
 tb/tb_scan_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 2-bit select through four codes, holding each for dwell+1 cycles.
// Define SCAN_GRAY_EN to scan in Gray order (00,01,11,10) instead of binary order.
module scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output logic               wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [1:0]         sel, sel_nx;
    logic [DWELL_W-1:0] dcnt, dcnt_nx;
    logic               one_pass, one_pass_nx;
    logic               wrap_nx;

`ifdef SCAN_GRAY_EN
    localparam logic [1:0] LAST_CODE = 2'b10;

    function automatic logic [1:0] next_code(input logic [1:0] code);
        return {code[0], ~code[1]};
    endfunction
`else
    localparam logic [1:0] LAST_CODE = 2'b11;

    function automatic logic [1:0] next_code(input logic [1:0] code);
        return code + 2'b01;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 2'b00;
            dcnt     <= '0;
            one_pass <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            dcnt     <= dcnt_nx;
            one_pass <= one_pass_nx;
            wrap     <= wrap_nx;
        end
    end

    // Stop outranks pause, and pause outranks both the dwell countdown and the advance.
    always_comb begin
        state_nx    = state;
        sel_nx      = sel;
        dcnt_nx     = dcnt;
        one_pass_nx = one_pass;
        wrap_nx     = 1'b0;
        case (state)
            IDLE: begin
                sel_nx = 2'b00;
                if (start && !stop) begin
                    state_nx    = SCAN;
                    dcnt_nx     = dwell;
                    one_pass_nx = single;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_nx    = IDLE;
                    sel_nx      = 2'b00;
                    dcnt_nx     = '0;
                    one_pass_nx = 1'b0;
                end else if (!pause) begin
                    if (dcnt != '0) begin
                        dcnt_nx = dcnt - DWELL_W'(1);
                    end else begin
                        sel_nx  = next_code(sel);
                        dcnt_nx = dwell;
                        if (sel == LAST_CODE) begin
                            wrap_nx = 1'b1;
                            if (one_pass) begin
                                state_nx    = IDLE;
                                dcnt_nx     = '0;
                                one_pass_nx = 1'b0;
                            end
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                sel_nx   = 2'b00;
            end
        endcase
    end

    assign s0   = sel[1];
    assign s1   = sel[0];
    assign busy = (state == SCAN);

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized scoreboard bench for scan_sequencer against a slot/age reference model.
// Honours SCAN_GRAY_EN so the expected code order follows the same build option.
module tb_scan_sequencer;

    localparam int DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               pause = 1'b0;
    logic               single = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic               s0, s1, busy, wrap;

    scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .pause (pause),
        .single(single),
        .dwell (dwell),
        .s0    (s0),
        .s1    (s1),
        .busy  (busy),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       wrap;
    } expect_t;

    expect_t expq[$];
    int      checks = 0;
    int      failures = 0;
    int      cycle = 0;

    // Reference model: which of the four slots is showing, how long it has shown,
    // and how long it must show in total.
    logic [1:0] seq_codes [4];
    logic       m_busy = 1'b0;
    int         m_slot = 0;
    int         m_age = 0;
    int         m_hold = 1;
    logic       m_one = 1'b0;
    logic       m_wrap = 1'b0;

    initial begin
`ifdef SCAN_GRAY_EN
        seq_codes[0] = 2'b00; seq_codes[1] = 2'b01; seq_codes[2] = 2'b11; seq_codes[3] = 2'b10;
`else
        seq_codes[0] = 2'b00; seq_codes[1] = 2'b01; seq_codes[2] = 2'b10; seq_codes[3] = 2'b11;
`endif
    end

    function automatic expect_t model_view();
        expect_t e;
        e.sel  = seq_codes[m_slot];
        e.busy = m_busy;
        e.wrap = m_wrap;
        return e;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_slot = 0;
        m_age  = 0;
        m_one  = 1'b0;
        m_wrap = 1'b0;
    endtask

    task automatic model_step();
        m_wrap = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (start && !stop) begin
                m_busy = 1'b1;
                m_slot = 0;
                m_age  = 0;
                m_hold = int'(dwell) + 1;
                m_one  = single;
            end
        end else if (stop) begin
            m_busy = 1'b0;
            m_slot = 0;
        end else if (!pause) begin
            if (m_age + 1 < m_hold) begin
                m_age++;
            end else begin
                m_age  = 0;
                m_hold = int'(dwell) + 1;
                if (m_slot == 3) begin
                    m_slot = 0;
                    m_wrap = 1'b1;
                    if (m_one) m_busy = 1'b0;
                end else begin
                    m_slot++;
                end
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model, and queues the post-edge expectation.
    task automatic applyStimulus(input logic st, input logic sp, input logic pa,
                                 input logic si, input int dw);
        start  = st;
        stop   = sp;
        pause  = pa;
        single = si;
        dwell  = DWELL_W'(dw);
        model_step();
        @(posedge clk);
        #1;
        cycle++;
        expq.push_back(model_view());
    endtask

    // Drops rst_n between edges; the pending expectation becomes the reset view,
    // which the monitor samples before the next rising edge.
    task automatic midCycleReset();
        #1;
        rst_n = 1'b0;
        model_reset();
        expq[expq.size()-1] = model_view();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic checkOutput(input expect_t e);
        checks++;
        if ({s0, s1} !== e.sel) begin
            failures++;
            $display("[TB] FAIL sel cycle %0d: got %b expected %b", cycle, {s0, s1}, e.sel);
        end
        checks++;
        if (busy !== e.busy) begin
            failures++;
            $display("[TB] FAIL busy cycle %0d: got %b expected %b", cycle, busy, e.busy);
        end
        checks++;
        if (wrap !== e.wrap) begin
            failures++;
            $display("[TB] FAIL wrap cycle %0d: got %b expected %b", cycle, wrap, e.wrap);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) checkOutput(expq.pop_front());
    end

    initial begin
        logic st, sp, pa, si;
        int   dw;
        model_reset();
        @(posedge clk);
        #1;
        expq.push_back(model_view());
        rst_n = 1'b1;

        // Free-running binary/Gray pass with dwell 0, plus idle cycles after.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Single pass, dwell 2, with dwell wiggling mid-slot.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2);
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, (i % 3 == 1) ? 7 : 2);

        // Pause for five cycles at the second code.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3);
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3);

        // Stop together with pause, then start with stop in idle, start ignored mid-scan.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1);

        // Asynchronous reset while showing the last code.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
        midCycleReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 3000; i++) begin
            st = ($urandom % 6) == 0;
            sp = ($urandom % 50) == 0;
            pa = ($urandom % 7) == 0;
            si = ($urandom % 3) == 0;
            dw = (($urandom % 10) == 0) ? int'($urandom % 16) : int'($urandom % 4);
            if (($urandom % 400) == 0) midCycleReset();
            else applyStimulus(st, sp, pa, si, dw);
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
